// File: rtl/bird_motion.sv
// Vertical motion stage for the bird: integrates gravity and flap impulses on each
// rising edge of the frame enable and clamps the height between ceiling and floor.
module bird_motion #(
  parameter int Y_START  = 240,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 460,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -6,
  parameter int VMAX     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] state,
  input  logic       flap,
  output logic [9:0] bird_y,
  output logic [5:0] velocity,
  output logic       at_floor,
  output logic       at_ceiling
);

  localparam logic signed [11:0] Y_MIN_S  = 12'(Y_MIN);
  localparam logic signed [11:0] Y_MAX_S  = 12'(Y_MAX);
  localparam logic signed [6:0]  VMAX_S   = 7'(VMAX);
  localparam logic signed [6:0]  GRAV_S   = 7'(GRAVITY);
  localparam logic signed [5:0]  FLAP_S   = 6'(FLAP_VEL);

  logic              enable_q;
  logic              flap_q;
  logic              pending;

  logic              tick;
  logic              flap_rise;
  logic              is_play;
  logic              is_over;
  logic              is_idle;
  logic signed [6:0] v_inc;
  logic signed [5:0] v_new;
  logic signed [11:0] sum;
  logic              pend_next;
  logic [9:0]        y_next;
  logic [5:0]        v_next;

  // Next-state computation: edge detect, velocity selection, clamped position.
  always_comb begin
    tick      = enable & ~enable_q;
    flap_rise = flap & ~flap_q;
    is_play   = (state == 2'd1);
    is_over   = (state == 2'd2);
    is_idle   = ~is_play & ~is_over;
    v_inc     = 7'({velocity[5], velocity}) + GRAV_S;
    v_new     = (v_inc > VMAX_S) ? VMAX_S[5:0] : v_inc[5:0];
    pend_next = 1'b0;
    y_next    = bird_y;
    v_next    = velocity;

    // Flaps only count while playing; the tick consumes any pending one.
    if (is_play) begin
      if (pending || flap_rise) v_new = FLAP_S;
      pend_next = tick ? 1'b0 : (pending | flap_rise);
    end

    sum = $signed({2'b00, bird_y}) + 12'(v_new);

    if (is_idle) begin
      y_next = 10'(Y_START);
      v_next = 6'd0;
    end else if (tick) begin
      if (sum < Y_MIN_S) begin
        y_next = 10'(Y_MIN);
        v_next = 6'd0;
      end else if (sum > Y_MAX_S) begin
        y_next = 10'(Y_MAX);
        v_next = 6'd0;
      end else begin
        y_next = sum[9:0];
        v_next = v_new;
      end
    end
  end

  // Edge-detector history resets high so a level held through reset is not an event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q <= 1'b1;
      flap_q   <= 1'b1;
      pending  <= 1'b0;
      bird_y   <= 10'(Y_START);
      velocity <= 6'd0;
    end else begin
      enable_q <= enable;
      flap_q   <= flap;
      pending  <= pend_next;
      bird_y   <= y_next;
      velocity <= v_next;
    end
  end

  assign at_floor   = (bird_y == 10'(Y_MAX));
  assign at_ceiling = (bird_y == 10'(Y_MIN));

endmodule

// File: tb/tb_bird_motion.sv
// Self-checking bench for bird_motion: directed scenarios plus randomized
// enable/flap/state traffic compared each clock against an integer reference model.
module tb_bird_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       flap = 1'b0;
  logic [1:0] state = 2'd0;
  logic [9:0] bird_y;
  logic [5:0] velocity;
  logic       at_floor;
  logic       at_ceiling;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, plain integers.
  int m_y = 240;
  int m_v = 0;
  bit m_pend = 1'b0;
  bit m_enq = 1'b1;
  bit m_flq = 1'b1;

  bird_motion dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .state      (state),
    .flap       (flap),
    .bird_y     (bird_y),
    .velocity   (velocity),
    .at_floor   (at_floor),
    .at_ceiling (at_ceiling)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input integer obs, input integer exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 240; m_v = 0; m_pend = 1'b0; m_enq = 1'b1; m_flq = 1'b1;
  endtask

  // Spec-level behaviour for one clock edge given the inputs at that edge.
  task automatic model_edge();
    bit tk, fr, play, over;
    int vn, s;
    if (!reset) begin
      model_reset();
      return;
    end
    tk   = enable && !m_enq;
    fr   = flap && !m_flq;
    play = (state == 2'd1);
    over = (state == 2'd2);
    if (!play && !over) begin
      m_y = 240; m_v = 0; m_pend = 1'b0;
    end else begin
      if (tk) begin
        if (play && (m_pend || fr)) vn = -6;
        else vn = (m_v + 1 > 8) ? 8 : m_v + 1;
        s = m_y + vn;
        if (s < 0) begin m_y = 0; m_v = 0; end
        else if (s > 460) begin m_y = 460; m_v = 0; end
        else begin m_y = s; m_v = vn; end
      end
      if (!play) m_pend = 1'b0;
      else if (tk) m_pend = 1'b0;
      else if (fr) m_pend = 1'b1;
    end
    m_enq = enable;
    m_flq = flap;
  endtask

  task automatic check_model();
    chk("bird_y", bird_y, m_y);
    chk("velocity", $signed(velocity), m_v);
    chk("at_floor", at_floor, (m_y == 460));
    chk("at_ceiling", at_ceiling, (m_y == 0));
  endtask

  task automatic cyc(input logic en, input logic fl);
    enable = en;
    flap   = fl;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic frame(input int hi, input int lo, input logic fl_hi, input logic fl_lo);
    repeat (hi) cyc(1'b1, fl_hi);
    repeat (lo) cyc(1'b0, fl_lo);
  endtask

  int ff_y[4] = '{241, 243, 246, 250};

  initial begin
    // Reset values without any clock edge.
    #1 reset = 1'b0;
    #1 check_model();
    chk("rst_y", bird_y, 240);
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);

    // Free fall with 4-high / 4-low enable.
    state = 2'd1;
    for (int k = 0; k < 4; k++) begin
      frame(4, 4, 1'b0, 1'b0);
      chk("ff_vel", $signed(velocity), k + 1);
      chk("ff_y", bird_y, ff_y[k]);
    end

    // One-clock flap between ticks.
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    frame(4, 4, 1'b0, 1'b0);
    chk("flap_vel", $signed(velocity), -6);
    chk("flap_y", bird_y, 244);
    frame(4, 4, 1'b0, 1'b0);
    chk("flap2_vel", $signed(velocity), -5);
    chk("flap2_y", bird_y, 239);

    // Flap held over three ticks gives a single load.
    frame(4, 4, 1'b1, 1'b1);
    chk("hold1_vel", $signed(velocity), -6);
    frame(4, 4, 1'b1, 1'b1);
    chk("hold2_vel", $signed(velocity), -5);
    frame(4, 4, 1'b1, 1'b1);
    chk("hold3_vel", $signed(velocity), -4);
    chk("hold3_y", bird_y, 224);
    cyc(1'b0, 1'b0);

    // Fall to the floor and stay there.
    repeat (50) frame(1, 1, 1'b0, 1'b0);
    chk("floor_y", bird_y, 460);
    chk("floor_vel", $signed(velocity), 0);
    chk("floor_flag", at_floor, 1);
    frame(1, 1, 1'b0, 1'b0);
    chk("floor_rest_y", bird_y, 460);

    // Flap every tick up to the ceiling.
    repeat (77) frame(1, 1, 1'b1, 1'b0);
    chk("ceil_y", bird_y, 0);
    chk("ceil_vel", $signed(velocity), 0);
    chk("ceil_flag", at_ceiling, 1);

    // OVER ignores flaps and falls to the floor.
    state = 2'd2;
    repeat (80) frame(1, 1, 1'b1, 1'b0);
    chk("over_y", bird_y, 460);
    chk("over_flag", at_floor, 1);

    // IDLE reloads on the next clock.
    state = 2'd0;
    cyc(1'b0, 1'b0);
    chk("idle_y", bird_y, 240);
    chk("idle_vel", $signed(velocity), 0);

    // Asynchronous reset mid-fall, released with enable already high.
    state = 2'd1;
    repeat (12) frame(1, 1, 1'b0, 1'b0);
    chk("prerst_y", bird_y, 308);
    enable = 1'b1;
    reset = 1'b0;
    #2;
    model_reset();
    check_model();
    chk("async_rst_y", bird_y, 240);
    cyc(1'b1, 1'b0);
    reset = 1'b1;
    repeat (3) cyc(1'b1, 1'b0);
    chk("post_rst_hold_y", bird_y, 240);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("post_rst_tick_y", bird_y, 241);
    chk("post_rst_tick_vel", $signed(velocity), 1);

    // Randomized traffic against the reference model.
    for (int seg = 0; seg < 12; seg++) begin
      if ($urandom_range(0, 3) != 0) state = 2'd1;
      else state = 2'($urandom_range(0, 3));
      for (int c = 0; c < 60; c++)
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bird_motion.md
# bird_motion

Vertical motion stage for the bird: integrates gravity and flap impulses once per frame tick and produces the `bird_y` that the pipe/position stage and the collision checker consume. It sits directly upstream of the position block. It takes that block's game `state` and the shared frame `enable`, and outputs the bird height plus floor and ceiling flags.

## Interface
- `Y_START`, 240: bird height loaded in IDLE and at reset (pixels, top edge).
- `Y_MIN`, 0: ceiling clamp.
- `Y_MAX`, 460: floor clamp (screen height 480 minus bird height 20).
- `GRAVITY`, 1: velocity increment per tick.
- `FLAP_VEL`, -6: velocity loaded on a flap (signed).
- `VMAX`, 8: terminal downward velocity.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset (0 = reset asserted).
- `enable` input 1: frame tick level. It may stay high for several clocks; only its rising edge advances motion.
- `state` input 2: game state from position block. 2'd0 IDLE, 2'd1 PLAYING, 2'd2 OVER, 2'd3 treated as IDLE.
- `flap` input 1: flap button level, already synchronous to `clk`.
- `bird_y` output 10: current bird top-edge height.
- `velocity` output 6: signed current vertical velocity (positive = down).
- `at_floor` output 1: high when `bird_y == Y_MAX`.
- `at_ceiling` output 1: high when `bird_y == Y_MIN`.

## Operation
- Edge detectors:
  - `tick = enable & ~enable_q` and `flap_rise = flap & ~flap_q`.
  - `enable_q` and `flap_q` reset to 1, so a level already high when reset releases is not an event.
- Flap pending bit:
  - Set on `flap_rise` in PLAYING.
  - Cleared by the tick that consumes it.
  - Forced to 0 in IDLE and OVER.
  - A button held across many ticks produces one flap.
- IDLE (every clock): `bird_y = Y_START`, `velocity = 0`, pending = 0.
- PLAYING, on tick:
  - If pending or `flap_rise` in that same cycle: `v_new = FLAP_VEL`.
  - Otherwise: `v_new = min(velocity + GRAVITY, VMAX)`.
- OVER, on tick: flaps are ignored and `v_new = min(velocity + GRAVITY, VMAX)`, so the bird falls to the floor and rests there.
- Position update, applied in PLAYING and OVER on tick:
  - `sum = zero-extended bird_y (12 bit signed) + sign-extended v_new`.
  - `sum < Y_MIN`: `bird_y = Y_MIN`, `velocity = 0`.
  - `sum > Y_MAX`: `bird_y = Y_MAX`, `velocity = 0`.
  - Otherwise: `bird_y = sum[9:0]`, `velocity = v_new`.
- No tick: `bird_y` and `velocity` hold; only pending may change.
- Parameters are constrained so that `FLAP_VEL` and `VMAX` fit in 6-bit signed, and `Y_MIN < Y_START < Y_MAX < 1024`.

## Timing
- Reset values (immediate on `reset` low, no clock needed):
  - `bird_y = Y_START`, `velocity = 0`, pending = 0.
  - `at_floor = 0`, `at_ceiling = 0` (for default parameters).
  - `enable_q = 1`, `flap_q = 1`.
- Latency:
  - `bird_y` and `velocity` update on the clock edge where `enable` is first sampled high after being low.
  - New values are visible the following cycle.
  - Exactly one update per `enable` pulse regardless of pulse width.
- Flags are decoded combinationally from the `bird_y` register. They change in the same cycle as `bird_y`, with no additional latency.
- State change:
  - `state` is sampled every clock.
  - IDLE loads take effect on the next edge, independent of tick.
  - On IDLE→PLAYING, the first tick starts from `velocity` 0.
- A flap rising edge in the same cycle as a tick is applied in that tick.
- A flap rising edge in the cycle after a tick waits for the next tick.
- Reset mid-fall or mid-flap: all registers return to reset values asynchronously. Motion resumes only after `reset` high and a fresh `enable` rising edge.

## Test plan
- Reset: assert `reset`=0 mid-run with `bird_y`=300 → `bird_y`=240, `velocity`=0 without a clock edge. After release with `enable` already high → no update until `enable` falls and rises.
- Free fall in PLAYING, no flap, `enable` high 4 clk / low 4 clk → after ticks 1..4: `velocity` = 1,2,3,4 and `bird_y` = 241,243,246,250. Ticks 9+ hold `velocity` at 8.
- Flap one-clock pulse between ticks with `bird_y`=250, `velocity`=4 → next tick gives `velocity`=-6, `bird_y`=244, and the tick after gives `velocity`=-5, `bird_y`=239. Holding `flap` high for 3 ticks yields only one -6 load.
- Floor clamp: `bird_y`=455, `velocity`=7, tick → `bird_y`=460, `velocity`=0, `at_floor`=1. A further tick gives `bird_y`=460 at `velocity` 0 after clamp.
- Ceiling clamp: `bird_y`=3, flap + tick → `bird_y`=0, `velocity`=0, `at_ceiling`=1.
- OVER then IDLE: `state`=2 with flaps pulsed → flaps ignored and the bird falls to 460. Then `state`=0 → next clock `bird_y`=240 and `velocity`=0.
